hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Master-side HILO execution unit. It executes the HILO-class ALU ops that the slave ALU does not handle: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Multiplication is pipelined.
- Division is iterative, radix-2 restoring.
- Sits in the master EX stage; the pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- MUL_LATENCY, 1: number of MUL-state cycles, legal 1..3. Extra product register stages are added for timing.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception/branch flush; aborts any in-flight op
- start  in  1  op valid in EX this cycle
- alu_op  in  6  operation code from alu_op.vh
- src_a  in  32  rs: dividend, multiplicand, or MTHI/MTLO data
- src_b  in  32  rt: divisor or multiplier
- busy  out  1  unit occupied; pipeline must stall
- done  out  1  one-cycle pulse; hi/lo already hold the new result
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. On reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counters cleared.
- States:
  - IDLE
  - MUL
  - DIV
  - DONE
- Outputs from state: busy = (state==MUL or DIV). done = (state==DONE).
- Accepting ops:
  - start is honoured only in IDLE or DONE, and only with flush=0.
  - DONE with no start goes to IDLE.
  - start while busy is ignored; the bench flags it as a protocol error.
- MTHI/MTLO: written on the next edge (hi<=src_a or lo<=src_a). No busy, no done, state goes to IDLE.
- MULT/MULTU: 64-bit signed/unsigned product of src_a×src_b.
  - MUL state lasts MUL_LATENCY cycles.
  - {hi,lo} is written on the edge leaving MUL; next state is DONE.
  - With MUL_LATENCY=1: busy in cycle 1, done in cycle 2.
- MADD/MADDU: {hi,lo} <= {hi,lo} + product, modulo 2^64. Timing is the same as MULT.
- MSUB/MSUBU: {hi,lo} <= {hi,lo} - product, modulo 2^64. Timing is the same as MULT.
- DIV/DIVU:
  - At start, latch magnitudes (signed ops only), sign flags and the divisor.
  - 32 restoring iterations, one per cycle; counter runs 0..31. busy is high for exactly 32 cycles.
  - On the edge of iteration 31, write lo=quotient and hi=remainder after sign fix-up:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - Next state is DONE, so done is high in cycle 33.
  - 0x80000000 / -1 (signed) gives lo=0x80000000, hi=0. No trap.
- Divide by zero (src_b==0):
  - Same 32-cycle timing and done pulse.
  - hi/lo are left unchanged (the architecture defines this case as unpredictable; the unit makes it deterministic).
- flush:
  - In any state, the next state is IDLE; in-flight results are discarded and hi/lo are unchanged.
  - done is not pulsed. flush in a DONE cycle only suppresses a new start.
  - flush and start in the same cycle: start is ignored.
- rst mid-operation behaves like flush, plus it clears hi/lo to 0.
- Unknown alu_op with start: treated as a no-op; no state change.

Decomposition:
- Opcodes ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU, ALU_DIV, ALU_DIVU, ALU_MTHI and ALU_MTLO are added to the shared alu_op.vh.
- The state enum and the DIV_ITERS=32 constant go in the shared cpu_defs package.
- One sub-module, div_radix2_iter.
  - Inputs: clk, rst, abort, start, unsigned dividend/divisor.
  - Outputs: quotient, remainder, valid.
  - The top level does the sign handling and HI/LO writeback.

Test Plan:
1. MTHI, src_a=0x12345678, then MTLO, src_a=0x9ABCDEF0 on consecutive cycles -> after 2 edges hi=0x12345678, lo=0x9ABCDEF0; busy and done never assert.
2. MULT 0xFFFFFFFF×0x00000002 -> done in cycle 2 (MUL_LATENCY=1), hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
3. Preload hi=0, lo=0xFFFFFFFF, then MADDU 1×1 -> hi=1, lo=0. Then MSUBU 1×1 -> hi=0, lo=0xFFFFFFFF.
4. DIV -7/2 -> busy for exactly 32 cycles, done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 with hi=0xAA, lo=0xBB -> done after 33 cycles, hi/lo unchanged.
6. Flush and reset:
   - Start DIVU, flush in cycle 10 -> busy drops on the next edge, no done, hi/lo unchanged; an immediately following MULT 3×3 gives lo=9.
   - rst mid-DIV -> hi=lo=0, idle.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HILO multiply/divide unit: opcode encodings
// for the HILO-class ALU ops, the unit FSM state type, the divider iteration
// count and an opcode decoder used by the top level.
package hilo_muldiv_unit_pkg;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // How the product combines with the current {hi,lo}.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_t;

  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;
  localparam logic [5:0] ALU_MADD  = 6'h1C;
  localparam logic [5:0] ALU_MADDU = 6'h1D;
  localparam logic [5:0] ALU_MSUB  = 6'h1E;
  localparam logic [5:0] ALU_MSUBU = 6'h1F;

  typedef struct packed {
    logic mthi;
    logic mtlo;
    logic mul;
    logic div;
    logic is_signed;
    acc_t acc;
  } op_dec_t;

  // Unknown opcodes decode to all-zero, which the top treats as a no-op.
  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      ALU_MTHI:  d.mthi = 1'b1;
      ALU_MTLO:  d.mtlo = 1'b1;
      ALU_MULT:  begin d.mul = 1'b1; d.is_signed = 1'b1; end
      ALU_MULTU: d.mul = 1'b1;
      ALU_MADD:  begin d.mul = 1'b1; d.is_signed = 1'b1; d.acc = ACC_ADD; end
      ALU_MADDU: begin d.mul = 1'b1; d.acc = ACC_ADD; end
      ALU_MSUB:  begin d.mul = 1'b1; d.is_signed = 1'b1; d.acc = ACC_SUB; end
      ALU_MSUBU: begin d.mul = 1'b1; d.acc = ACC_SUB; end
      ALU_DIV:   begin d.div = 1'b1; d.is_signed = 1'b1; end
      ALU_DIVU:  d.div = 1'b1;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div.sv
// div_radix2_iter: unsigned radix-2 restoring divider, one quotient bit per
// cycle, DIV_ITERS iterations.
//   clk, rst       clock, synchronous active-high reset
//   abort          drop the in-flight division
//   start          load dividend/divisor and begin iterating
//   dividend       unsigned dividend
//   divisor        unsigned divisor
//   quotient       result quotient (valid while valid=1)
//   remainder      result remainder (valid while valid=1)
//   valid          high during the last iteration cycle; quotient/remainder
//                  show the values being produced by that iteration
module div_radix2_iter
  import hilo_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] dvsr_q;
  logic [4:0]  cnt;
  logic        running;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quot_next;

  // Dividend bits shift out of quot_q into the partial remainder while
  // quotient bits shift in from the bottom.
  always_comb begin
    shifted = {rem_q, quot_q[31]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[32]) begin
      rem_next  = trial[31:0];
      quot_next = {quot_q[30:0], 1'b1};
    end else begin
      rem_next  = shifted[31:0];
      quot_next = {quot_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (abort) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem_q   <= '0;
      quot_q  <= dividend;
      dvsr_q  <= divisor;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem_q  <= rem_next;
      quot_q <= quot_next;
      cnt    <= cnt + 5'd1;
      if (cnt == LAST_ITER) begin
        running <= 1'b0;
      end
    end
  end

  assign quotient  = quot_next;
  assign remainder = rem_next;
  assign valid     = running && (cnt == LAST_ITER);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: master-side HILO execution unit. Owns HI/LO and executes
// MULT/MULTU, MADD/MADDU, MSUB/MSUBU (pipelined multiply), DIV/DIVU
// (iterative divider) and MTHI/MTLO.
//   MUL_LATENCY    MUL-state cycles (1..3); extra product register stages
//   clk, rst       clock, synchronous active-high reset (clears hi/lo)
//   flush          abort in-flight op, suppress same-cycle start
//   start          op valid this cycle (honoured in IDLE/DONE only)
//   alu_op         operation code
//   src_a, src_b   operands (src_a also carries MTHI/MTLO data)
//   busy           multiply or divide in progress; stall the pipeline
//   done           one-cycle pulse, hi/lo already updated
//   hi, lo         architectural HI/LO
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [5:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] MUL_LAST = 2'(MUL_LATENCY - 1);

  state_t  state;
  op_dec_t dec;
  logic    accept;

  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  acc_t               mul_acc;
  logic [1:0]         mul_cnt;
  logic [63:0]        prod_comb;
  logic [63:0]        prod_final;
  logic [63:0]        mul_result;

  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_valid;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign dec    = decode_op(alu_op);
  assign accept = start && !flush && (state == ST_IDLE || state == ST_DONE);

  // Operands are held sign- or zero-extended to 33 bits so one signed
  // multiplier serves both flavours; the low 64 bits are the result.
  assign prod_comb = 64'(mul_a * mul_b);

  if (MUL_LATENCY > 1) begin : g_pipe
    logic [63:0] stage [MUL_LATENCY-1];
    always_ff @(posedge clk) begin
      stage[0] <= prod_comb;
      for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) begin
        stage[i] <= stage[i-1];
      end
    end
    assign prod_final = stage[MUL_LATENCY-2];
  end else begin : g_comb
    assign prod_final = prod_comb;
  end

  always_comb begin
    case (mul_acc)
      ACC_ADD: mul_result = {hi, lo} + prod_final;
      ACC_SUB: mul_result = {hi, lo} - prod_final;
      default: mul_result = prod_final;
    endcase
  end

  // Divider works on magnitudes; signs are restored at writeback.
  always_comb begin
    mag_a = (dec.is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b = (dec.is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
    quo_fix = q_neg ? (~div_quo + 32'd1) : div_quo;
    rem_fix = r_neg ? (~div_rem + 32'd1) : div_rem;
  end

  div_radix2_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (accept && dec.div),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= ACC_NONE;
      mul_cnt  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            if (dec.mthi) begin
              hi <= src_a;
            end else if (dec.mtlo) begin
              lo <= src_a;
            end else if (dec.mul) begin
              mul_a   <= {dec.is_signed & src_a[31], src_a};
              mul_b   <= {dec.is_signed & src_b[31], src_b};
              mul_acc <= dec.acc;
              mul_cnt <= '0;
              state   <= ST_MUL;
            end else if (dec.div) begin
              q_neg    <= dec.is_signed & (src_a[31] ^ src_b[31]);
              r_neg    <= dec.is_signed & src_a[31];
              div_zero <= (src_b == '0);
              state    <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (mul_cnt == MUL_LAST) begin
            {hi, lo} <= mul_result;
            state    <= ST_DONE;
          end else begin
            mul_cnt <= mul_cnt + 2'd1;
          end
        end
        ST_DIV: begin
          if (div_valid) begin
            if (!div_zero) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_MUL) || (state == ST_DIV);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit. A reference model computes the
// expected {hi,lo} when each op is driven and pushes it to a queue; the entry
// is popped and compared when the unit reports completion.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int unsigned ML = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [5:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.MUL_LATENCY(ML)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .alu_op (alu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_div(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic bit is_mt(input logic [5:0] op);
    return (op == ALU_MTHI) || (op == ALU_MTLO);
  endfunction

  // Reference model: updates m_hi/m_lo and queues the expected {hi,lo}.
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] qv;
    logic [63:0] rv;
    longint sa;
    longint sb;
    acc = {m_hi, m_lo};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      ALU_MTHI: m_hi = a;
      ALU_MTLO: m_lo = a;
      ALU_MULT, ALU_MADD, ALU_MSUB, ALU_MULTU, ALU_MADDU, ALU_MSUBU: begin
        if (op == ALU_MULT || op == ALU_MADD || op == ALU_MSUB) p = 64'(sa * sb);
        else p = ua * ub;
        if (op == ALU_MADD || op == ALU_MADDU) acc = acc + p;
        else if (op == ALU_MSUB || op == ALU_MSUBU) acc = acc - p;
        else acc = p;
        {m_hi, m_lo} = acc;
      end
      ALU_DIV: if (b != 0) begin
        qv = 64'(sa / sb);
        rv = 64'(sa % sb);
        m_lo = qv[31:0];
        m_hi = rv[31:0];
      end
      ALU_DIVU: if (b != 0) begin
        qv = ua / ub;
        rv = ua % ub;
        m_lo = qv[31:0];
        m_hi = rv[31:0];
      end
      default: ;
    endcase
    exp_q.push_back({m_hi, m_lo});
  endtask

  // Called just after a negedge; returns at the negedge after the start edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    alu_op = op;
    src_a  = a;
    src_b  = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {hi, lo}, e);
    end
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned cyc;
    int unsigned nbusy;
    model(op, a, b);
    drive(op, a, b);
    if (is_mt(op)) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      pop_check(tag);
    end else begin
      cyc = 1;
      nbusy = 0;
      while (!done && cyc < 100) begin
        if (busy) nbusy++;
        @(negedge clk);
        cyc++;
      end
      check({tag, "_done_cyc"}, 64'(cyc), is_div(op) ? 64'(DIV_ITERS + 1) : 64'(ML + 1));
      check({tag, "_busy_cyc"}, 64'(nbusy), is_div(op) ? 64'(DIV_ITERS) : 64'(ML));
      pop_check(tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rops [6];
    int unsigned seen;
    rops = '{ALU_MULT, ALU_MULTU, ALU_MADD, ALU_MSUBU, ALU_DIV, ALU_DIVU};
    rst = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    alu_op = '0;
    src_a = '0;
    src_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    do_op("mthi", ALU_MTHI, 32'h12345678, 32'h0);
    do_op("mtlo", ALU_MTLO, 32'h9ABCDEF0, 32'h0);

    do_op("mult", ALU_MULT, 32'hFFFFFFFF, 32'h2);
    do_op("multu", ALU_MULTU, 32'hFFFFFFFF, 32'h2);

    do_op("pre_hi", ALU_MTHI, 32'h0, 32'h0);
    do_op("pre_lo", ALU_MTLO, 32'hFFFFFFFF, 32'h0);
    do_op("maddu", ALU_MADDU, 32'h1, 32'h1);
    do_op("msubu", ALU_MSUBU, 32'h1, 32'h1);
    do_op("madd", ALU_MADD, 32'hFFFFFFFF, 32'h5);
    do_op("msub", ALU_MSUB, 32'h80000000, 32'h3);

    do_op("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'h2);
    do_op("divu", ALU_DIVU, 32'd100, 32'd7);
    do_op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_op("div_nr", ALU_DIV, 32'd7, 32'hFFFFFFFE);

    do_op("pre_hi2", ALU_MTHI, 32'hAA, 32'h0);
    do_op("pre_lo2", ALU_MTLO, 32'hBB, 32'h0);
    do_op("div_zero", ALU_DIVU, 32'd5, 32'd0);

    // flush mid-divide
    drive(ALU_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    do_op("post_flush_mult", ALU_MULT, 32'd3, 32'd3);

    // flush together with start: start ignored
    flush = 1'b1;
    drive(ALU_MULT, 32'd4, 32'd4);
    flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);

    // unknown opcode is a no-op
    drive(6'h3F, 32'h55, 32'h66);
    check("unk_busy", {63'd0, busy}, 64'd0);
    check("unk_hilo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 8; i++) begin
      logic [5:0] op;
      logic [31:0] a;
      logic [31:0] b;
      op = rops[$urandom_range(0, 5)];
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op("rand", op, a, b);
    end

    // reset mid-divide
    drive(ALU_DIV, 32'd50, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_mid_quiet", 64'(seen), 64'd0);
    check("rst_mid_hilo2", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
